// File: rtl/imem_pkg.sv
// imem_sync shared types and constants.
// Loader state encoding, byte width and fault fill value.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_t;

    localparam int BYTE_W = 8;

    // Fill bit replicated across rd when a fetch faults.
    localparam bit FAULT_BIT = 1'b0;

    function automatic int lanes_of(input int dw);
        return dw / BYTE_W;
    endfunction

endpackage

// File: rtl/imem_sync_if.sv
// Fetch and program-load bus of imem_sync.
// IMEM_FAULT_EN adds the fetch_fault response bit.
interface imem_sync_if #(
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_ready;
    logic              stall;
    logic [DATA_W-1:0] rd;
    logic              rd_valid;
    logic              load_start;
    logic              load_byte_valid;
    logic [7:0]        load_byte;
    logic              load_last;
    logic              load_busy;
    logic              load_done;
    logic              load_overflow;
`ifdef IMEM_FAULT_EN
    logic              fetch_fault;

    modport master (
        output fetch_req, fetch_addr, stall,
        output load_start, load_byte_valid, load_byte, load_last,
        input  fetch_ready, rd, rd_valid, fetch_fault,
        input  load_busy, load_done, load_overflow
    );

    modport slave (
        input  fetch_req, fetch_addr, stall,
        input  load_start, load_byte_valid, load_byte, load_last,
        output fetch_ready, rd, rd_valid, fetch_fault,
        output load_busy, load_done, load_overflow
    );
`else
    modport master (
        output fetch_req, fetch_addr, stall,
        output load_start, load_byte_valid, load_byte, load_last,
        input  fetch_ready, rd, rd_valid,
        input  load_busy, load_done, load_overflow
    );

    modport slave (
        input  fetch_req, fetch_addr, stall,
        input  load_start, load_byte_valid, load_byte, load_last,
        output fetch_ready, rd, rd_valid,
        output load_busy, load_done, load_overflow
    );
`endif
endinterface

// File: rtl/imem_loader.sv
// Byte-serial program loader for imem_sync.
// Assembles little-endian words and emits RAM writes.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_byte_valid,
    input  logic [BYTE_W-1:0] load_byte,
    input  logic              load_last,
    output logic              idle,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_overflow,
    output logic              wr_en,
    output logic [AW-1:0]     wr_idx,
    output logic [DATA_W-1:0] wr_data
);

    localparam int LANES = lanes_of(DATA_W);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW    = AW + 1;

    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [PW-1:0] PTR_END   = PW'(DEPTH);

    ld_state_t         state;
    ld_state_t         state_nx;
    logic [LW-1:0]     byte_cnt;
    logic [PW-1:0]     word_ptr;
    logic [DATA_W-1:0] asm_q;
    logic [DATA_W-1:0] asm_nx;
    logic              ovf_q;
    logic              take;
    logic              word_end;
    logic              in_range;
    logic              start;

    assign start    = (state == IDLE) && load_start;
    assign take     = (state == LOAD) && load_byte_valid;
    assign word_end = take && ((byte_cnt == LAST_LANE) || load_last);
    assign in_range = word_ptr < PTR_END;

    // Loader state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: start, last byte, single-cycle done.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (load_start) state_nx = LOAD;
            LOAD:    if (take && load_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Drop the incoming byte into its lane of the word.
    always_comb begin
        asm_nx = asm_q;
        asm_nx[byte_cnt*BYTE_W +: BYTE_W] = load_byte;
    end

    // Byte lane, word pointer and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            byte_cnt <= '0;
            word_ptr <= '0;
            asm_q    <= '0;
            ovf_q    <= 1'b0;
        end else if (take) begin
            if (word_end) begin
                byte_cnt <= '0;
                asm_q    <= '0;
                if (in_range) begin
                    word_ptr <= word_ptr + 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end else begin
                byte_cnt <= byte_cnt + 1'b1;
                asm_q    <= asm_nx;
            end
        end
    end

    assign wr_en         = word_end && in_range;
    assign wr_idx        = word_ptr[AW-1:0];
    assign wr_data       = asm_nx;
    assign idle          = (state == IDLE);
    assign load_busy     = !idle;
    assign load_done     = (state == DONE);
    assign load_overflow = ovf_q;

endmodule

// File: rtl/imem_sync.sv
// Clocked instruction memory with fetch handshake and loader.
// Optional IMEM_FAULT_EN: misaligned/out-of-range fault reporting.
module imem_sync
    import imem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter     INIT_FILE = ""
) (
    input logic        clk,
    input logic        reset,
    imem_sync_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_en;
    logic [AW-1:0]     wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              ld_idle;
    logic              accept;
    logic              addr_bad;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] rd_q;
    logic              vld_q;
    logic              flt_q;

    imem_loader #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_loader (
        .clk             (clk),
        .reset           (reset),
        .load_start      (bus.load_start),
        .load_byte_valid (bus.load_byte_valid),
        .load_byte       (bus.load_byte),
        .load_last       (bus.load_last),
        .idle            (ld_idle),
        .load_busy       (bus.load_busy),
        .load_done       (bus.load_done),
        .load_overflow   (bus.load_overflow),
        .wr_en           (wr_en),
        .wr_idx          (wr_idx),
        .wr_data         (wr_data)
    );

    assign idx    = bus.fetch_addr[AW+1:2];
    assign accept = bus.fetch_req && ld_idle && !bus.stall;

`ifdef IMEM_FAULT_EN
    assign addr_bad = (|bus.fetch_addr[1:0]) ||
                      (|bus.fetch_addr[31:AW+2]);
`else
    logic unused_addr;
    assign addr_bad    = 1'b0;
    assign unused_addr = ^{bus.fetch_addr[31:AW+2],
                           bus.fetch_addr[1:0]};
`endif

    // Loader write port; fetch is blocked while it is active.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Registered read; stall freezes the whole response.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            vld_q <= 1'b0;
            flt_q <= 1'b0;
        end else if (!bus.stall) begin
            vld_q <= accept;
            flt_q <= accept && addr_bad;
            if (accept) begin
                rd_q <= addr_bad ? {DATA_W{FAULT_BIT}} : mem[idx];
            end
        end
    end

    assign bus.fetch_ready = ld_idle;
    assign bus.rd          = rd_q;
    assign bus.rd_valid    = vld_q;

`ifdef IMEM_FAULT_EN
    assign bus.fetch_fault = flt_q;
`else
    logic unused_flt;
    assign unused_flt = flt_q;
`endif

endmodule

// File: tb/tb_imem_sync.sv
// Self-checking bench for imem_sync.
// Reference: word array plus byte-image packing rules.
module tb_imem_sync;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset;

    int vecs = 0;
    int errs = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] erd;
    logic        evalid;
    logic        efault;
    logic        eovf;
    bit          busy;

    imem_sync_if #(.DATA_W(32)) bus ();

    imem_sync #(
        .DEPTH     (DEPTH),
        .DATA_W    (32),
        .INIT_FILE ("")
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit fault_of(input logic [31:0] a);
`ifdef IMEM_FAULT_EN
        return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 0);
`else
        return (a === 32'hx);
`endif
    endfunction

    // One clock; update the expected response and compare it.
    task automatic cyc();
        logic [31:0] a;
        logic acc, bad, rst, stl;
        a   = bus.fetch_addr;
        rst = reset;
        stl = bus.stall;
        acc = bus.fetch_req && !busy && !stl;
        bad = fault_of(a);
        @(posedge clk);
        #1;
        if (rst) begin
            erd    = '0;
            evalid = 1'b0;
            efault = 1'b0;
        end else if (!stl) begin
            evalid = acc;
            efault = acc && bad;
            if (acc) erd = bad ? 32'h0 : model[(a >> 2) % DEPTH];
        end
        check("rd_valid", bus.rd_valid, evalid);
        check("rd", bus.rd, erd);
`ifdef IMEM_FAULT_EN
        check("fetch_fault", bus.fetch_fault, efault);
`endif
    endtask

    task automatic fetch(input logic [31:0] a);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        bus.stall      = 1'b0;
        cyc();
        bus.fetch_req  = 1'b0;
    endtask

    // Drive an image; the model packs it four bytes per word.
    task automatic do_load(input logic [7:0] img[$],
                           input bit with_fetch,
                           input logic [31:0] faddr);
        int n, nw, k;
        logic [31:0] w;
        n  = img.size();
        nw = (n + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int l = 0; l < 4; l++)
                if (i * 4 + l < n) w[l*8 +: 8] = img[i*4 + l];
            if (i < DEPTH) model[i] = w;
        end
        eovf = (nw > DEPTH);

        busy           = 1'b0;
        bus.load_start = 1'b1;
        bus.fetch_req  = with_fetch;
        bus.fetch_addr = faddr;
        bus.stall      = 1'b0;
        cyc();
        bus.load_start = 1'b0;
        busy           = 1'b1;
        check("busy_after_start", bus.load_busy, 1'b1);
        check("ready_after_start", bus.fetch_ready, 1'b0);

        k = 0;
        while (k < n) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.load_byte_valid = 1'b0;
                bus.load_last       = 1'($urandom);
                bus.load_byte       = 8'($urandom);
            end else begin
                bus.load_byte_valid = 1'b1;
                bus.load_byte       = img[k];
                bus.load_last       = (k == n - 1);
                k++;
            end
            bus.fetch_req  = 1'($urandom);
            bus.fetch_addr = $urandom;
            bus.stall      = ($urandom_range(0, 3) == 0);
            bus.load_start = 1'($urandom);
            cyc();
            check("ready_in_load", bus.fetch_ready, 1'b0);
            if (k < n) check("done_early", bus.load_done, 1'b0);
        end
        check("load_done", bus.load_done, 1'b1);
        check("busy_done", bus.load_busy, 1'b1);

        bus.load_byte_valid = 1'b0;
        bus.load_last       = 1'b0;
        bus.load_start      = 1'b0;
        bus.fetch_req       = 1'b0;
        bus.stall           = 1'b0;
        cyc();
        busy = 1'b0;
        check("done_pulse", bus.load_done, 1'b0);
        check("busy_idle", bus.load_busy, 1'b0);
        check("ready_idle", bus.fetch_ready, 1'b1);
        check("overflow", bus.load_overflow, eovf);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) fetch(32'(i * 4));
    endtask

    initial begin
        logic [7:0] img[$];
        logic [31:0] a;

        reset               = 1'b1;
        busy                = 1'b0;
        eovf                = 1'b0;
        erd                 = '0;
        evalid              = 1'b0;
        efault              = 1'b0;
        bus.fetch_req       = 1'b0;
        bus.fetch_addr      = '0;
        bus.stall           = 1'b0;
        bus.load_start      = 1'b0;
        bus.load_byte_valid = 1'b0;
        bus.load_byte       = '0;
        bus.load_last       = 1'b0;

        cyc();
        cyc();
        check("rst_busy", bus.load_busy, 1'b0);
        check("rst_done", bus.load_done, 1'b0);
        check("rst_ovf", bus.load_overflow, 1'b0);
        check("rst_ready", bus.fetch_ready, 1'b1);
        reset = 1'b0;
        cyc();

        img = {};
        for (int i = 0; i < DEPTH; i++) begin
            a = 32'hE000_0000 + i;
            for (int l = 0; l < 4; l++) img.push_back(a[l*8 +: 8]);
        end
        do_load(img, 1'b0, '0);

        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h0;
        cyc();
        check("seq0", bus.rd, 32'hE000_0000);
        bus.fetch_addr = 32'h4;
        cyc();
        check("seq1", bus.rd, 32'hE000_0001);
        bus.fetch_addr = 32'h8;
        cyc();
        check("seq2", bus.rd, 32'hE000_0002);

        bus.fetch_addr = 32'h10;
        cyc();
        check("pre_stall", bus.rd, 32'hE000_0004);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.fetch_addr = 32'(i * 4 + 20);
            cyc();
            check("stall_rd", bus.rd, 32'hE000_0004);
            check("stall_vld", bus.rd_valid, 1'b1);
        end
        bus.stall     = 1'b0;
        bus.fetch_req = 1'b0;
        cyc();
        check("post_stall_vld", bus.rd_valid, 1'b0);
        check("post_stall_rd", bus.rd, 32'hE000_0004);

        img = {8'h0F, 8'h00, 8'h4F, 8'hE0, 8'h0F, 8'h10};
        do_load(img, 1'b1, 32'h8);
        fetch(32'h4);
        check("ld_word1", bus.rd, 32'h0000_100F);
        fetch(32'h0);
        check("ld_word0", bus.rd, 32'hE04F_000F);
        fetch(32'h8);
        check("ld_word2_kept", bus.rd, 32'hE000_0002);

        for (int r = 0; r < 3; r++) begin
            img = {};
            for (int i = 0; i < $urandom_range(1, DEPTH * 4); i++)
                img.push_back(8'($urandom));
            do_load(img, 1'($urandom), 32'($urandom_range(0, DEPTH - 1) * 4));
            read_all();
        end

        img = {};
        for (int i = 0; i < DEPTH * 4 + 4; i++) img.push_back(8'($urandom));
        do_load(img, 1'b0, '0);
        check("ovf_flag", bus.load_overflow, 1'b1);
        read_all();
        fetch(32'((DEPTH - 1) * 4));
        check("ovf_last_word", bus.rd,
              {img[DEPTH*4-1], img[DEPTH*4-2], img[DEPTH*4-3], img[DEPTH*4-4]});

        bus.load_start = 1'b1;
        cyc();
        bus.load_start = 1'b0;
        busy           = 1'b1;
        check("ovf_clear", bus.load_overflow, 1'b0);
        bus.load_byte_valid = 1'b1;
        bus.load_byte       = 8'hAA;
        cyc();
        bus.load_byte       = 8'h55;
        cyc();
        bus.load_byte_valid = 1'b0;
        reset               = 1'b1;
        cyc();
        busy  = 1'b0;
        reset = 1'b0;
        check("rst_mid_busy", bus.load_busy, 1'b0);
        check("rst_mid_ready", bus.fetch_ready, 1'b1);
        fetch(32'h0);
        read_all();

        for (int i = 0; i < 300; i++) begin
            bus.fetch_req  = 1'($urandom);
            bus.stall      = ($urandom_range(0, 3) == 0);
            bus.fetch_addr = ($urandom_range(0, 3) == 0) ? $urandom
                           : 32'($urandom_range(0, DEPTH - 1) * 4);
            cyc();
        end
        bus.fetch_req = 1'b0;
        bus.stall     = 1'b0;

`ifdef IMEM_FAULT_EN
        fetch(32'h2);
        check("fault_mis_rd", bus.rd, 32'h0);
        check("fault_mis", bus.fetch_fault, 1'b1);
        fetch(32'(DEPTH * 4));
        check("fault_oor", bus.fetch_fault, 1'b1);
        fetch(32'h4);
        check("fault_ok", bus.fetch_fault, 1'b0);
`else
        fetch(32'(DEPTH * 4));
        check("alias_rd", bus.rd, model[0]);
        fetch(32'(DEPTH * 4 + 7));
        check("alias_rd1", bus.rd, model[1]);
`endif
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
